// File: rtl/sram_access_arbiter.sv
// Shares one external SRAM between a CPU port and an aux port, sequencing each cycle as IDLE/ACCESS/RECOVER.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the CPU has fixed priority.
//
// state   | meaning
// IDLE    | strobes high, arbitrate and latch the winning request
// ACCESS  | CE/UB/LB low, OE or WE low, wait counter running
// RECOVER | strobes high, write data still driven, ack to the granted port
module sram_access_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              aux_ack,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic              dq_oe
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic              grant_aux, grant_aux_next;
    logic              we_lat, we_lat_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] wdata_next;
    logic              pick_aux;
    logic              any_req;
    logic              capture;
    logic              access_next;
    logic              drive_next;

    assign any_req = cpu_req | aux_req;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_aux;

    // On a tie the port that did not win last time gets the bus.
    assign pick_aux = aux_req & (~cpu_req | ~last_aux);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            last_aux <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_aux <= pick_aux;
        end
    end
`else
    assign pick_aux = aux_req & ~cpu_req;
`endif

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        grant_aux_next = grant_aux;
        we_lat_next    = we_lat;
        addr_next      = ADDR;
        wdata_next     = Data_to_SRAM;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next     = ACCESS;
                    cnt_next       = CNT_INIT;
                    grant_aux_next = pick_aux;
                    we_lat_next    = pick_aux ? aux_we    : cpu_we;
                    addr_next      = pick_aux ? aux_addr  : cpu_addr;
                    wdata_next     = pick_aux ? aux_wdata : cpu_wdata;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_next = RECOVER;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pins are decoded from the next state so they come straight off flops.
    assign access_next = (state_next == ACCESS);
    assign drive_next  = we_lat_next & (state_next == ACCESS || state_next == RECOVER);
    assign capture     = (state == ACCESS) && (cnt == 4'd0) && !we_lat;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            grant_aux    <= 1'b0;
            we_lat       <= 1'b0;
            ADDR         <= '0;
            Data_to_SRAM <= '0;
            CE           <= 1'b1;
            OE           <= 1'b1;
            WE           <= 1'b1;
            dq_oe        <= 1'b0;
            cpu_ack      <= 1'b0;
            aux_ack      <= 1'b0;
            cpu_rdata    <= '0;
            aux_rdata    <= '0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            grant_aux    <= grant_aux_next;
            we_lat       <= we_lat_next;
            ADDR         <= addr_next;
            Data_to_SRAM <= wdata_next;
            CE           <= ~access_next;
            OE           <= ~(access_next & ~we_lat_next);
            WE           <= ~(access_next & we_lat_next);
            dq_oe        <= drive_next;
            cpu_ack      <= (state_next == RECOVER) & ~grant_aux_next;
            aux_ack      <= (state_next == RECOVER) & grant_aux_next;
            if (capture) begin
                if (grant_aux) begin
                    aux_rdata <= Data_from_SRAM;
                end else begin
                    cpu_rdata <= Data_from_SRAM;
                end
            end
        end
    end

    assign UB = CE;
    assign LB = CE;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: directed scenarios plus a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_sram_access_arbiter;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int W  = 1;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    logic          cpu_req, cpu_we, aux_req, aux_we;
    logic [AW-1:0] cpu_addr, aux_addr;
    logic [DW-1:0] cpu_wdata, aux_wdata, cpu_rdata, aux_rdata;
    logic          cpu_ack, aux_ack;
    logic          CE, UB, LB, OE, WE, dq_oe;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] Data_to_SRAM, Data_from_SRAM;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] ref_mem [16];
    logic          ovr_en;
    logic [DW-1:0] ovr_data;
    assign Data_from_SRAM = ovr_en ? ovr_data : mem[ADDR[3:0]];
    always @(posedge Clk) if (!CE && !WE) mem[ADDR[3:0]] <= Data_to_SRAM;

    // second instance with zero wait states, CPU port only
    logic          z_req, z_we, z_aux_req, z_aux_we;
    logic [AW-1:0] z_addr, z_aux_addr, z_ADDR;
    logic [DW-1:0] z_wdata, z_aux_wdata, z_rdata, z_aux_rdata, z_dout, z_din;
    logic          z_ack, z_aux_ack, z_CE, z_UB, z_LB, z_OE, z_WE, z_dq_oe;
    logic [DW-1:0] z_ovr;
    assign z_din = z_ovr;

    sram_access_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_rdata(aux_rdata), .aux_ack(aux_ack),
        .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR),
        .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM), .dq_oe(dq_oe)
    );

    sram_access_arbiter #(.WAIT_CYCLES(0), .ADDR_W(AW), .DATA_W(DW)) dut0 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(z_req), .cpu_we(z_we), .cpu_addr(z_addr), .cpu_wdata(z_wdata),
        .cpu_rdata(z_rdata), .cpu_ack(z_ack),
        .aux_req(z_aux_req), .aux_we(z_aux_we), .aux_addr(z_aux_addr), .aux_wdata(z_aux_wdata),
        .aux_rdata(z_aux_rdata), .aux_ack(z_aux_ack),
        .CE(z_CE), .UB(z_UB), .LB(z_LB), .OE(z_OE), .WE(z_WE), .ADDR(z_ADDR),
        .Data_to_SRAM(z_dout), .Data_from_SRAM(z_din), .dq_oe(z_dq_oe)
    );

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset;
        Reset = 1'b0;
        #2;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
    endtask

    task automatic test_reset;
        #7;
        tests++;
        if ({CE, UB, LB, OE, WE, dq_oe, cpu_ack, aux_ack} !== 8'b11111000) begin
            fails++;
            $display("FAIL reset_pins got %b want 11111000", {CE, UB, LB, OE, WE, dq_oe, cpu_ack, aux_ack});
        end
        tests++;
        if (cpu_rdata !== 16'h0 || aux_rdata !== 16'h0 || ADDR !== 20'h0 || Data_to_SRAM !== 16'h0) begin
            fails++;
            $display("FAIL reset_regs got rd %h/%h addr %h wd %h want all 0", cpu_rdata, aux_rdata, ADDR, Data_to_SRAM);
        end
        tick;
        Reset = 1'b1;
        tick;
        tests++;
        if ({CE, OE, WE, dq_oe, cpu_ack, aux_ack} !== 6'b111000) begin
            fails++;
            $display("FAIL idle_after_reset got %b want 111000", {CE, OE, WE, dq_oe, cpu_ack, aux_ack});
        end
    endtask

    task automatic test_cpu_read;
        int ce_lo = 0, oe_lo = 0, we_lo = 0, ack_at = -1;
        logic [DW-1:0] rd_at_ack = '0;
        ovr_en = 1'b1; ovr_data = 16'hBEEF;
        cpu_we = 1'b0; cpu_addr = 20'h00012; cpu_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (!CE) ce_lo++;
            if (!OE) oe_lo++;
            if (!WE) we_lo++;
            if (cpu_ack && ack_at < 0) begin
                ack_at = i; rd_at_ack = cpu_rdata; cpu_req = 1'b0; ovr_data = 16'h0000;
            end
        end
        ovr_en = 1'b0;
        tests++;
        if (ce_lo != 2 || oe_lo != 2 || we_lo != 0) begin
            fails++;
            $display("FAIL read_strobes got ce %0d oe %0d we %0d low want 2 2 0", ce_lo, oe_lo, we_lo);
        end
        tests++;
        if (ack_at != 2) begin
            fails++;
            $display("FAIL read_ack_latency got %0d want 2", ack_at);
        end
        tests++;
        if (rd_at_ack !== 16'hBEEF || cpu_rdata !== 16'hBEEF) begin
            fails++;
            $display("FAIL read_data got %h (later %h) want beef", rd_at_ack, cpu_rdata);
        end
    endtask

    task automatic test_cpu_write;
        int we_lo = 0, oe_lo = 0, dq_hi = 0, bad_d = 0, ack_at = -1;
        cpu_we = 1'b1; cpu_addr = 20'h0FFFF; cpu_wdata = 16'h1234; cpu_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (!WE) we_lo++;
            if (!OE) oe_lo++;
            if (dq_oe) dq_hi++;
            if (dq_oe && Data_to_SRAM !== 16'h1234) bad_d++;
            if (cpu_ack && ack_at < 0) begin
                ack_at = i; cpu_req = 1'b0;
            end
        end
        tests++;
        if (we_lo != 2 || dq_hi != 3 || oe_lo != 0 || bad_d != 0) begin
            fails++;
            $display("FAIL write_strobes got we %0d dq %0d oe %0d bad %0d want 2 3 0 0", we_lo, dq_hi, oe_lo, bad_d);
        end
        tests++;
        if (ack_at != 2 || cpu_rdata !== 16'hBEEF) begin
            fails++;
            $display("FAIL write_ack got at %0d rdata %h want 2 beef", ack_at, cpu_rdata);
        end
        tests++;
        if (mem[15] !== 16'h1234) begin
            fails++;
            $display("FAIL write_mem got %h want 1234", mem[15]);
        end
    endtask

    task automatic test_simultaneous;
        int order [4];
        int exp_order [4];
        int n = 0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        do_reset;
        cpu_we = 1'b0; cpu_addr = 20'h00003;
        aux_we = 1'b0; aux_addr = 20'h00004;
        cpu_req = 1'b1; aux_req = 1'b1;
        for (int i = 0; i < 40 && n < 4; i++) begin
            tick;
            if (cpu_ack && n < 4) begin order[n] = 0; n++; end
            if (aux_ack && n < 4) begin order[n] = 1; n++; end
        end
        cpu_req = 1'b0; aux_req = 1'b0;
        tests++;
        if (n != 4) begin
            fails++;
            $display("FAIL arb_ack_count got %0d want 4", n);
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (k < n && order[k] != exp_order[k]) begin
                fails++;
                $display("FAIL arb_order[%0d] got %0d want %0d (0=cpu 1=aux)", k, order[k], exp_order[k]);
            end
        end
        repeat (4) tick;
    endtask

    task automatic test_aux_during_cpu;
        int cpu_at = -1, aux_at = -1, aux_ce = -1, early = 0;
        cpu_we = 1'b0; cpu_addr = 20'h00030;
        aux_we = 1'b0; aux_addr = 20'h00041;
        cpu_req = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick;
            if (i == 0) aux_req = 1'b1;
            if (cpu_ack && cpu_at < 0) begin cpu_at = i; cpu_req = 1'b0; end
            if (!CE && ADDR === 20'h00041 && aux_ce < 0) aux_ce = i;
            if (aux_ack && cpu_at < 0) early++;
            if (aux_ack && aux_at < 0) begin aux_at = i; aux_req = 1'b0; end
        end
        tests++;
        if (cpu_at != 2 || early != 0) begin
            fails++;
            $display("FAIL mid_cpu_ack got %0d early %0d want 2 0", cpu_at, early);
        end
        tests++;
        if (aux_ce != cpu_at + 2 || aux_at != cpu_at + 4) begin
            fails++;
            $display("FAIL mid_aux_start got ce %0d ack %0d want %0d %0d", aux_ce, aux_at, cpu_at + 2, cpu_at + 4);
        end
    endtask

    task automatic test_reset_mid_write;
        int acks = 0, ce_lo = 0, ack_at = -1;
        cpu_we = 1'b1; cpu_addr = 20'h00005; cpu_wdata = 16'hAAAA; cpu_req = 1'b1;
        tick;
        tests++;
        if (WE !== 1'b0 || dq_oe !== 1'b1) begin
            fails++;
            $display("FAIL abort_started got we %b dq %b want 0 1", WE, dq_oe);
        end
        #2;
        Reset = 1'b0;
        #1;
        tests++;
        if ({WE, CE, dq_oe, cpu_ack} !== 4'b1100) begin
            fails++;
            $display("FAIL abort_async got %b want 1100", {WE, CE, dq_oe, cpu_ack});
        end
        cpu_req = 1'b0;
        tick; tick;
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (cpu_ack) acks++;
            if (!CE) ce_lo++;
        end
        tests++;
        if (acks != 0 || ce_lo != 0 || cpu_rdata !== 16'h0) begin
            fails++;
            $display("FAIL abort_quiet got acks %0d ce %0d rdata %h want 0 0 0000", acks, ce_lo, cpu_rdata);
        end
        ovr_en = 1'b1; ovr_data = 16'hC3C3;
        cpu_we = 1'b0; cpu_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (cpu_ack && ack_at < 0) begin ack_at = i; cpu_req = 1'b0; end
        end
        ovr_en = 1'b0;
        tests++;
        if (ack_at != 2 || cpu_rdata !== 16'hC3C3) begin
            fails++;
            $display("FAIL abort_reread got at %0d rdata %h want 2 c3c3", ack_at, cpu_rdata);
        end
    endtask

    task automatic test_back_to_back;
        int a1 = -1, a2 = -1, ce_lo = 0, bad_ub = 0;
        logic [DW-1:0] r1 = '0, r2 = '0;
        z_ovr = 16'h1111; z_we = 1'b0; z_addr = 20'h00000; z_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (!z_CE) ce_lo++;
            if (z_UB !== z_CE || z_LB !== z_CE) bad_ub++;
            if (z_ack) begin
                if (a1 < 0) begin
                    a1 = i; r1 = z_rdata; z_addr = 20'h00001; z_ovr = 16'h2222;
                end else if (a2 < 0) begin
                    a2 = i; r2 = z_rdata; z_req = 1'b0;
                end
            end
        end
        tests++;
        if (a1 != 1 || a2 != 4) begin
            fails++;
            $display("FAIL w0_ack_timing got %0d %0d want 1 4", a1, a2);
        end
        tests++;
        if (r1 !== 16'h1111 || r2 !== 16'h2222) begin
            fails++;
            $display("FAIL w0_rdata got %h %h want 1111 2222", r1, r2);
        end
        tests++;
        if (ce_lo != 2 || bad_ub != 0) begin
            fails++;
            $display("FAIL w0_strobes got ce %0d ub_bad %0d want 2 0", ce_lo, bad_ub);
        end
    endtask

    // Transaction-level model: one grant per free slot, fixed timeline per access.
    task automatic test_random;
        int free_at = 0, ack_edge = -100, g_edge = -100;
        bit m_we = 0, m_aux = 0, last_aux = 1, pick, c_pend = 0, a_pend = 0;
        bit in_acc, in_rec;
        logic [AW-1:0] m_addr = '0;
        logic [DW-1:0] m_wdata = '0, m_cpu_rd = '0, m_aux_rd = '0, m_pend_rd = '0;
        bit s_creq, s_cwe, s_areq, s_awe;
        logic [AW-1:0] s_caddr, s_aaddr;
        logic [DW-1:0] s_cwd, s_awd;
        logic [7:0] exp_pins;
        cpu_req = 1'b0; aux_req = 1'b0;
        do_reset;
        for (int k = 0; k < 16; k++) ref_mem[k] = mem[k];
        for (int e = 0; e < 600; e++) begin
            s_creq = cpu_req; s_cwe = cpu_we; s_caddr = cpu_addr; s_cwd = cpu_wdata;
            s_areq = aux_req; s_awe = aux_we; s_aaddr = aux_addr; s_awd = aux_wdata;
            tick;
            if (e == ack_edge && !m_we) begin
                if (m_aux) m_aux_rd = m_pend_rd; else m_cpu_rd = m_pend_rd;
            end
            if (e >= free_at && (s_creq || s_areq)) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                pick = s_areq && (!s_creq || !last_aux);
`else
                pick = s_areq && !s_creq;
`endif
                last_aux = pick;
                m_aux = pick;
                m_we = pick ? s_awe : s_cwe;
                m_addr = pick ? s_aaddr : s_caddr;
                m_wdata = pick ? s_awd : s_cwd;
                g_edge = e; ack_edge = e + W + 1; free_at = e + W + 3;
                if (m_we) ref_mem[m_addr[3:0]] = m_wdata;
                else m_pend_rd = ref_mem[m_addr[3:0]];
            end
            in_acc = (e >= g_edge) && (e <= g_edge + W);
            in_rec = (e == g_edge + W + 1);
            exp_pins = {!in_acc, !in_acc, !in_acc, !(in_acc && !m_we), !(in_acc && m_we),
                        m_we && (in_acc || in_rec), in_rec && !m_aux, in_rec && m_aux};
            tests++;
            if ({CE, UB, LB, OE, WE, dq_oe, cpu_ack, aux_ack} !== exp_pins) begin
                fails++;
                $display("FAIL rand_pins edge %0d got %b want %b", e, {CE, UB, LB, OE, WE, dq_oe, cpu_ack, aux_ack}, exp_pins);
            end
            tests++;
            if (ADDR !== m_addr || Data_to_SRAM !== m_wdata) begin
                fails++;
                $display("FAIL rand_bus edge %0d got %h/%h want %h/%h", e, ADDR, Data_to_SRAM, m_addr, m_wdata);
            end
            tests++;
            if (cpu_rdata !== m_cpu_rd || aux_rdata !== m_aux_rd) begin
                fails++;
                $display("FAIL rand_rdata edge %0d got %h/%h want %h/%h", e, cpu_rdata, aux_rdata, m_cpu_rd, m_aux_rd);
            end
            if (in_rec && !m_aux) c_pend = 0;
            if (in_rec && m_aux) a_pend = 0;
            if (!c_pend && $urandom_range(0, 2) == 0) begin
                c_pend = 1; cpu_we = 1'($urandom); cpu_addr = 20'($urandom); cpu_wdata = 16'($urandom);
            end
            if (!a_pend && $urandom_range(0, 2) == 0) begin
                a_pend = 1; aux_we = 1'($urandom); aux_addr = 20'($urandom); aux_wdata = 16'($urandom);
            end
            cpu_req = c_pend; aux_req = a_pend;
        end
        cpu_req = 1'b0; aux_req = 1'b0;
    endtask

    initial begin
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
        ovr_en = 0; ovr_data = '0;
        z_req = 0; z_we = 0; z_addr = '0; z_wdata = '0; z_ovr = '0;
        z_aux_req = 0; z_aux_we = 0; z_aux_addr = '0; z_aux_wdata = '0;
        test_reset;
        test_cpu_read;
        test_cpu_write;
        test_simultaneous;
        test_aux_during_cpu;
        test_reset_mid_write;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_access_arbiter.md
# sram_access_arbiter

Sequences every external SRAM cycle and shares the single 1Mx16 SRAM between two requesters: the CPU-side memory port (MAR/MDR path) and an auxiliary port (DMA/display fetch). Each access runs through a fixed-length access phase with programmable wait states. The block drives the active-low CE/UB/LB/OE/WE strobes, the 20-bit address and the tristate write-enable, and returns read data with a one-cycle acknowledge. It sits between the requesters and the 16-bit tristate buffer feeding the SRAM pins.

## Interface
- WAIT_CYCLES, 1: extra access-phase cycles beyond the first; legal range 0..15.
- ADDR_W, 20: SRAM address width.
- DATA_W, 16: SRAM data width.

- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  read data, valid when cpu_ack is high.
- cpu_ack  out  1  one-cycle completion pulse.
- aux_req, aux_we, aux_addr, aux_wdata, aux_rdata, aux_ack: same directions, widths and meanings for the auxiliary port.
- CE, UB, LB, OE, WE  out  1 each  active-low SRAM strobes.
- ADDR  out  ADDR_W  SRAM address.
- Data_to_SRAM  out  DATA_W  write data to the tristate buffer.
- Data_from_SRAM  in  DATA_W  read data from the tristate buffer.
- dq_oe  out  1  tristate output enable; high drives the bus.

## Operation
- States: IDLE, ACCESS, RECOVER.
- IDLE: all strobes high, dq_oe=0. If any req is high at a rising edge:
  - latch the grant, we, addr and wdata;
  - load the wait counter with WAIT_CYCLES;
  - move to ACCESS.
- ACCESS:
  - CE=UB=LB=0.
  - Read: OE=0, WE=1.
  - Write: WE=0, OE=1, dq_oe=1.
  - ADDR and Data_to_SRAM come from latched values and are held constant.
  - Counter decrements each cycle. On the edge where counter==0, a read captures Data_from_SRAM into the granted port's rdata register, and the state moves to RECOVER.
- RECOVER: all strobes high. For a write, dq_oe stays 1 and Data_to_SRAM is held (data hold time). The granted port's ack=1 for exactly this cycle; the state returns to IDLE.
- A req still high in IDLE after its ack is treated as a new request.
- Arbitration happens only in IDLE; requests arriving mid-access wait.
- rdata of a port holds its last captured value until that port's next read completes. Writes do not modify rdata.
- ADDR and Data_to_SRAM hold their last latched values in IDLE/RECOVER.

## Timing
- Reset (Reset=0, asynchronous): state=IDLE, CE=UB=LB=OE=WE=1, dq_oe=0, cpu_ack=aux_ack=0, cpu_rdata=aux_rdata=0, ADDR=0, Data_to_SRAM=0, last-grant=aux.
- Reset asserted mid-access aborts the access immediately: strobes go high in the same cycle, no ack is issued, and no rdata is updated.
- Latency: req sampled high in IDLE at edge k, then:
  - ACCESS occupies cycles k+1 .. k+1+WAIT_CYCLES;
  - ack is high in cycle k+2+WAIT_CYCLES;
  - the next grant is possible at the edge ending the ack cycle's successor IDLE cycle.
- Throughput: one access per WAIT_CYCLES+3 cycles.
- WAIT_CYCLES=0: ACCESS lasts exactly 1 cycle.
- Strobes are registered outputs with no combinational path from req to pins.

## Configuration
- SRAM_ARB_ROUND_ROBIN_EN defined: when both reqs are high in IDLE, the port not granted last wins; last-grant updates on every grant.
- Not defined: fixed priority, and the CPU always wins on simultaneous requests (aux can starve); the last-grant register is omitted.

## Test plan
- CPU read, WAIT_CYCLES=1: addr 0x00012, SRAM returns 0xBEEF.
  - OE/CE low for exactly 2 cycles.
  - cpu_ack pulses 3 cycles after req is sampled, with cpu_rdata=0xBEEF.
- CPU write of 0x1234 to 0x0FFFF: WE low 2 cycles, dq_oe high 3 cycles (ACCESS+RECOVER), Data_to_SRAM=0x1234 throughout, OE stays high.
- Simultaneous requests:
  - Round-robin: both reqs held for 4 accesses produce grant order cpu, aux, cpu, aux.
  - Macro off: four cpu grants, aux never acked while cpu_req stays high.
- Aux request raised during a CPU ACCESS: aux is not granted until after cpu_ack; aux ACCESS starts 2 cycles after cpu_ack.
- Reset pulsed low during a write ACCESS: WE, CE and dq_oe deassert asynchronously, no ack, state IDLE; a following read of the same address completes normally.
- WAIT_CYCLES=0 back-to-back CPU reads of 0x0, 0x1 with req held: each ack is 2 cycles after grant, acks 3 cycles apart, rdata updates per read.
